// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: 4-deep sample delay line, double-buffered coefficient bank and paced MAC enable strobe.
// Optional feature macro: FIR_FEEDER_PRIME_EN (suppress enable until the delay line holds 4 real samples).
module fir_tap_feeder #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              coef_we,
  input  logic [1:0]        coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic              enable
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t            state, nxt;
  logic [3:0]        hold_cnt;
  logic [DATA_W-1:0] shadow [4];
  logic              accept, gate;
  assign accept = s_valid & s_ready;
`ifdef FIR_FEEDER_PRIME_EN
  logic [2:0] prime_cnt;
  // count accepted samples, saturating once the delay line is full of real data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prime_cnt <= '0;
    else if (accept && prime_cnt != 3'd4) prime_cnt <= prime_cnt + 3'd1;
  assign gate = prime_cnt >= 3'd3;
`else
  assign gate = 1'b1;
`endif
  // next-state: one ISSUE cycle after each accept, then HOLD until the counter drains
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (accept ? ISSUE : IDLE) :
          state == ISSUE ? HOLD :
          (hold_cnt == 4'd0 ? IDLE : HOLD);
  end
  // state register, hold counter and registered handshake/strobe outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      s_ready  <= 1'b0;
      enable   <= 1'b0;
    end else begin
      state    <= nxt;
      hold_cnt <= state == ISSUE ? 4'(HOLD_CYCLES - 1) :
                  (state == HOLD && hold_cnt != 4'd0) ? hold_cnt - 4'd1 : hold_cnt;
      s_ready  <= nxt == IDLE;
      enable   <= accept & gate;
    end
  // shadow bank is written at any time; only an accept copies it to the active bank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (coef_we) begin
      shadow[coef_addr] <= coef_data;
    end
  // taps shift and active coefficients reload only on an accept edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {x0, x1, x2, x3} <= '0;
      {a0, a1, a2, a3} <= '0;
    end else if (accept) begin
      {x0, x1, x2, x3} <= {s_data, x0, x1, x2};
      {a0, a1, a2, a3} <= {shadow[0], shadow[1], shadow[2], shadow[3]};
    end
endmodule

// File: tb/tb_fir_tap_feeder.sv
// tb_fir_tap_feeder: scoreboard bench for fir_tap_feeder with an independent cycle model.
module tb_fir_tap_feeder;
  localparam int HOLD = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic [7:0] x0, x1, x2, x3, a0, a1, a2, a3;
  logic       enable;
  int         vectors = 0;
  int         errors = 0;
  int         en_cnt = 0;
  logic [63:0] sb [$];
  logic [31:0] mx = '0, ma = '0;
  logic [7:0]  msh [4] = '{default: 8'h00};
  logic        m_ready = 1'b0, m_en = 1'b0, prev_ready = 1'b0;
  int          m_busy = 0, m_prime = 0;

  fir_tap_feeder #(.DATA_W(8), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .enable(enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: handshake pacing, taps, coefficient banks
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx = '0; ma = '0; msh = '{default: 8'h00};
      m_ready = 1'b0; m_en = 1'b0; m_busy = 0; m_prime = 0;
    end else begin
      if (s_valid && m_ready) begin
        mx = {s_data, mx[31:8]};
        ma = {msh[0], msh[1], msh[2], msh[3]};
        if (m_prime < 4) m_prime++;
`ifdef FIR_FEEDER_PRIME_EN
        m_en = m_prime >= 4;
`else
        m_en = 1'b1;
`endif
        m_ready = 1'b0;
        m_busy = HOLD + 1;
        sb.push_back({mx, ma});
      end else begin
        m_en = 1'b0;
        if (m_busy > 0) begin
          m_busy--;
          m_ready = m_busy == 0;
        end else m_ready = 1'b1;
      end
      if (coef_we) msh[coef_addr] = coef_data;
    end
  end

  // per-cycle compare plus scoreboard pop on every observed accept
  always @(negedge clk) begin
    check("s_ready", 64'(s_ready), 64'(m_ready));
    check("enable", 64'(enable), 64'(m_en));
    if (enable) en_cnt++;
    if (rst_n && prev_ready && !s_ready) begin
      if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("taps_coefs", {x0, x1, x2, x3, a0, a1, a2, a3}, sb.pop_front());
    end
    prev_ready = s_ready;
  end

  task automatic wr(input logic [1:0] ad, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = ad; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic we = 1'b0,
                      input logic [1:0] ad = 2'd0, input logic [7:0] cd = 8'd0);
    int n = 0;
    s_valid = 1'b1;
    while (!m_ready && n < 50) begin
      s_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (!m_ready) check("send_timeout", 64'd0, 64'd1);
    s_data = d; coef_we = we; coef_addr = ad; coef_data = cd;
    @(negedge clk);
    s_valid = 1'b0; coef_we = 1'b0; s_data = 8'($urandom);
  endtask

  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    #1;
    check("rst_x", 64'({x0, x1, x2, x3}), 64'd0);
    check("rst_a", 64'({a0, a1, a2, a3}), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("ready_rise", 64'(s_ready), 64'd1);
    check("idle_x", 64'({x0, x1, x2, x3}), 64'd0);
    wr(2'd0, 8'd2); wr(2'd1, 8'hFF); wr(2'd2, 8'd3); wr(2'd3, 8'd4);
    send(8'd5);
    check("first_a", 64'({a0, a1, a2, a3}), 64'h02FF0304);
    check("first_x", 64'({x0, x1, x2, x3}), 64'h05000000);
    n = 0;
    while (!s_ready && n < 10) begin n++; @(negedge clk); end
    check("ready_low_cycles", 64'(n), 64'(HOLD + 1));
    base = en_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i));
    check("b2b_x", 64'({x0, x1, x2, x3}), 64'h05040302);
    repeat (6) @(negedge clk);
`ifdef FIR_FEEDER_PRIME_EN
    check("en_pulses", 64'(en_cnt - base), 64'd3);
`else
    check("en_pulses", 64'(en_cnt - base), 64'd5);
`endif
    send(8'd8, 1'b1, 2'd1, 8'd7);
    check("a1_same_edge", 64'(a1), 64'hFF);
    send(8'd9);
    check("a1_next_accept", 64'(a1), 64'h07);
    send(8'd10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_x", 64'({x0, x1, x2, x3}), 64'd0);
    check("async_a", 64'({a0, a1, a2, a3}), 64'd0);
    check("async_ready", 64'(s_ready), 64'd0);
    check("async_enable", 64'(enable), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    base = en_cnt;
    repeat (4) @(negedge clk);
    check("no_enable_after_rst", 64'(en_cnt - base), 64'd0);
    send(8'd11);
    check("post_rst_x", 64'({x0, x1, x2, x3}), 64'h0B000000);
    check("post_rst_a", 64'({a0, a1, a2, a3}), 64'd0);
    repeat (8) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
